// File: rtl/inst_sequencer_pkg.sv
// Shared definitions for the instruction sequencer: default widths,
// opcode encoding and the positions of the instruction fields.
package inst_sequencer_pkg;

    // Default widths of the instruction memory interface and the repeat counter.
    localparam int INST_MEM_DEPTH = 12;
    localparam int INST_MEM_SIZE  = 32;
    localparam int REPEAT_LENGTH  = 28;

    // The opcode sits in the top nibble of every instruction word.
    localparam int OPCODE_W   = 4;
    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 28;

    // REPEAT carries its count in ir[27:0]; JUMP carries its target in ir[11:0].
    localparam int REP_FIELD_W  = 28;
    localparam int JUMP_FIELD_W = 12;

    typedef enum logic [OPCODE_W-1:0] {
        OP_NOP    = 4'd0,
        OP_EXEC   = 4'd1,
        OP_REPEAT = 4'd2,
        OP_JUMP   = 4'd3,
        OP_SYNC   = 4'd4,
        OP_HALT   = 4'd15
    } opcode_e;

endpackage

// File: rtl/inst_sequencer.sv
// Instruction sequencer: fetches instruction words from an external memory
// with one cycle of read latency, decodes them, and issues EXEC commands to
// the datapath over a valid/ready handshake. Supports repeat counts, jumps,
// a barrier on the neural units draining, halt and an abort input.
module inst_sequencer #(
    parameter int INST_MEM_DEPTH = inst_sequencer_pkg::INST_MEM_DEPTH,
    parameter int INST_MEM_SIZE  = inst_sequencer_pkg::INST_MEM_SIZE,
    parameter int REPEAT_LENGTH  = inst_sequencer_pkg::REPEAT_LENGTH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [INST_MEM_DEPTH-1:0] start_addr,
    input  logic                      stop,
    output logic                      inst_rd,
    output logic [INST_MEM_DEPTH-1:0] inst_addr,
    input  logic [INST_MEM_SIZE-1:0]  inst_data,
    output logic                      issue_valid,
    input  logic                      issue_ready,
    output logic [INST_MEM_SIZE-1:0]  issue_inst,
    input  logic                      nu_idle,
    output logic                      busy,
    output logic                      done,
    output logic                      err
);

    import inst_sequencer_pkg::*;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_MEMWAIT,
        ST_EXECUTE
    } state_t;

    state_t                    state_q, state_d;
    logic [INST_MEM_DEPTH-1:0] pc_q, pc_d;
    logic [INST_MEM_SIZE-1:0]  ir_q, ir_d;
    logic [REPEAT_LENGTH-1:0]  rep_cnt_q, rep_cnt_d;
    logic                      err_q, err_d;

    logic [OPCODE_W-1:0]       opcode;
    logic [INST_MEM_DEPTH-1:0] pc_inc;
    logic                      issue_fire;

    // Field extraction and the sequential successor address (wraps naturally).
    assign opcode     = ir_q[OPCODE_MSB:OPCODE_LSB];
    assign pc_inc     = pc_q + INST_MEM_DEPTH'(1);
    assign issue_fire = issue_valid && issue_ready;

    // Outputs that are pure functions of the registered state. Because they
    // derive from state_q, an asynchronous reset drops them in the same cycle.
    assign inst_addr  = pc_q;
    assign issue_inst = ir_q;
    assign busy       = (state_q != ST_IDLE);
    assign err        = err_q;

    // Next-state and output decode for the fetch/decode/execute loop.
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path
        // through the case statements can leave one unassigned and infer a latch.
        state_d     = state_q;
        pc_d        = pc_q;
        ir_d        = ir_q;
        rep_cnt_d   = rep_cnt_q;
        err_d       = err_q;
        inst_rd     = 1'b0;
        issue_valid = 1'b0;
        done        = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    pc_d    = start_addr;
                    err_d   = 1'b0;
                    state_d = ST_FETCH;
                end
            end

            ST_FETCH: begin
                inst_rd = 1'b1;
                state_d = ST_MEMWAIT;
            end

            ST_MEMWAIT: begin
                // Memory returns the word one cycle after the read strobe.
                ir_d    = inst_data;
                state_d = ST_EXECUTE;
            end

            ST_EXECUTE: begin
                unique case (opcode)
                    OP_NOP: begin
                        rep_cnt_d = '0;
                        pc_d      = pc_inc;
                        state_d   = ST_FETCH;
                    end

                    OP_EXEC: begin
                        // ir_q is frozen while in EXECUTE, so the command
                        // stays stable until the datapath takes it.
                        issue_valid = 1'b1;
                        if (issue_fire) begin
                            if (rep_cnt_q > REPEAT_LENGTH'(1)) begin
                                rep_cnt_d = rep_cnt_q - REPEAT_LENGTH'(1);
                            end else begin
                                rep_cnt_d = '0;
                                pc_d      = pc_inc;
                                state_d   = ST_FETCH;
                            end
                        end
                    end

                    OP_REPEAT: begin
                        // Counts of 0 and 1 both yield a single issue, since
                        // the EXEC branch only re-issues while rep_cnt > 1.
                        rep_cnt_d = REPEAT_LENGTH'(ir_q[REP_FIELD_W-1:0]);
                        pc_d      = pc_inc;
                        state_d   = ST_FETCH;
                    end

                    OP_JUMP: begin
                        rep_cnt_d = '0;
                        pc_d      = INST_MEM_DEPTH'(ir_q[JUMP_FIELD_W-1:0]);
                        state_d   = ST_FETCH;
                    end

                    OP_SYNC: begin
                        // Barrier: wait here until every neural unit drains.
                        rep_cnt_d = '0;
                        if (nu_idle) begin
                            pc_d    = pc_inc;
                            state_d = ST_FETCH;
                        end
                    end

                    OP_HALT: begin
                        rep_cnt_d = '0;
                        done      = 1'b1;
                        state_d   = ST_IDLE;
                    end

                    default: begin
                        // Unknown opcode: flag it and abandon the program.
                        rep_cnt_d = '0;
                        err_d     = 1'b1;
                        state_d   = ST_IDLE;
                    end
                endcase
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Abort overrides everything: back to IDLE, drop any repeat, keep pc
        // and err as they were, and never report completion.
        if (stop) begin
            state_d   = ST_IDLE;
            pc_d      = pc_q;
            ir_d      = ir_q;
            err_d     = err_q;
            rep_cnt_d = '0;
            done      = 1'b0;
        end
    end

    // State register with asynchronous active-high reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            pc_q      <= '0;
            ir_q      <= '0;
            rep_cnt_q <= '0;
            err_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // values from before this edge, independent of statement order.
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            rep_cnt_q <= rep_cnt_d;
            err_q     <= err_d;
        end
    end

endmodule

// File: tb/tb_inst_sequencer.sv
// Self-checking bench for inst_sequencer. Directed programs are loaded into a
// behavioural instruction memory; expected EXEC issues are pushed into a
// scoreboard queue and a negedge monitor pops and compares every accepted issue.
module tb_inst_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [11:0] start_addr = '0;
    logic        stop = 1'b0;
    logic        inst_rd;
    logic [11:0] inst_addr;
    logic [31:0] inst_data = '0;
    logic        issue_valid;
    logic        issue_ready = 1'b0;
    logic [31:0] issue_inst;
    logic        nu_idle = 1'b1;
    logic        busy;
    logic        done;
    logic        err;

    int compared   = 0;
    int mismatched = 0;
    int done_cnt   = 0;

    logic [31:0] mem [0:4095];
    logic [31:0] exp_q [$];

    logic        hold_valid = 1'b0;
    logic [31:0] hold_inst  = '0;

    localparam logic [31:0] HALT = 32'hF000_0000;
    localparam logic [31:0] NOP  = 32'h0000_0000;

    inst_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .start_addr  (start_addr),
        .stop        (stop),
        .inst_rd     (inst_rd),
        .inst_addr   (inst_addr),
        .inst_data   (inst_data),
        .issue_valid (issue_valid),
        .issue_ready (issue_ready),
        .issue_inst  (issue_inst),
        .nu_idle     (nu_idle),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

    always #5 clk = ~clk;

    // Instruction memory with one cycle of read latency.
    always @(posedge clk) begin
        if (inst_rd) inst_data <= mem[inst_addr];
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: compares every accepted issue against the queue and
    // checks that a stalled command does not change while it waits.
    always @(negedge clk) begin
        if (rst) begin
            hold_valid = 1'b0;
        end else begin
            if (issue_valid && issue_ready) begin
                if (exp_q.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL unexpected_issue: got 0x%0h expected none at %0t", issue_inst, $time);
                end else begin
                    check("issue_inst", issue_inst, exp_q.pop_front());
                end
            end
            if (hold_valid && issue_valid) check("issue_stable", issue_inst, hold_inst);
            hold_valid = issue_valid && !issue_ready;
            hold_inst  = issue_inst;
            if (done) done_cnt++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulses start for one sampling edge; returns in the FETCH cycle.
    task automatic do_start(input logic [11:0] addr);
        start_addr = addr;
        start      = 1'b1;
        tick();
        start      = 1'b0;
    endtask

    // Bounded wait for the done pulse, then confirm it lasts one cycle.
    task automatic wait_done(input string name, input int max_cycles, input bit toggle_ready);
        bit seen = 1'b0;
        for (int i = 0; i < max_cycles && !seen; i++) begin
            tick();
            if (toggle_ready) issue_ready = ~issue_ready;
            if (done) seen = 1'b1;
        end
        check(name, seen, 1'b1);
        tick();
        check({name, "_pulse_end"}, done, 1'b0);
        check({name, "_idle"}, busy, 1'b0);
    endtask

    initial begin
        int d0;
        for (int i = 0; i < 4096; i++) mem[i] = NOP;

        // Reset state
        repeat (2) tick();
        check("rst_busy", busy, 1'b0);
        check("rst_inst_rd", inst_rd, 1'b0);
        check("rst_issue_valid", issue_valid, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_pc", inst_addr, 12'd0);
        rst = 1'b0;
        tick();

        // Single EXEC then HALT: issue three cycles after start
        mem[0] = 32'h1000_0001;
        mem[1] = HALT;
        issue_ready = 1'b1;
        exp_q.push_back(32'h1000_0001);
        d0 = done_cnt;
        do_start(12'd0);
        check("t1_fetch_rd", inst_rd, 1'b1);
        check("t1_fetch_addr", inst_addr, 12'd0);
        check("t1_busy", busy, 1'b1);
        tick();
        check("t1_memwait_rd", inst_rd, 1'b0);
        check("t1_memwait_valid", issue_valid, 1'b0);
        tick();
        check("t1_issue_valid", issue_valid, 1'b1);
        tick();
        check("t1_after_accept_valid", issue_valid, 1'b0);
        check("t1_next_addr", inst_addr, 12'd1);
        tick();
        tick();
        check("t1_done", done, 1'b1);
        tick();
        check("t1_done_low", done, 1'b0);
        check("t1_idle", busy, 1'b0);
        check("t1_done_count", done_cnt - d0, 1);
        check("t1_sb_empty", exp_q.size(), 0);

        // REPEAT 5 with ready toggling: five issues, stable while stalled
        mem[12'h10] = 32'h2000_0005;
        mem[12'h11] = 32'h1ABC_DEF0;
        mem[12'h12] = HALT;
        repeat (5) exp_q.push_back(32'h1ABC_DEF0);
        issue_ready = 1'b1;
        do_start(12'h010);
        wait_done("t2_done", 60, 1'b1);
        check("t2_sb_empty", exp_q.size(), 0);

        // REPEAT cleared by an intervening NOP: single issue
        mem[12'h20] = 32'h2000_0003;
        mem[12'h21] = NOP;
        mem[12'h22] = 32'h1000_0022;
        mem[12'h23] = HALT;
        issue_ready = 1'b1;
        exp_q.push_back(32'h1000_0022);
        do_start(12'h020);
        wait_done("t3_done", 40, 1'b0);
        check("t3_sb_empty", exp_q.size(), 0);

        // JUMP skips over an EXEC
        mem[12'h60] = 32'h3000_0062;
        mem[12'h61] = 32'h1000_0BAD;
        mem[12'h62] = 32'h1000_0062;
        mem[12'h63] = HALT;
        exp_q.push_back(32'h1000_0062);
        do_start(12'h060);
        wait_done("t_jump_done", 40, 1'b0);
        check("t_jump_sb_empty", exp_q.size(), 0);

        // SYNC holds until nu_idle, then fetches the next address
        mem[12'h30] = 32'h4000_0000;
        mem[12'h31] = HALT;
        nu_idle = 1'b0;
        do_start(12'h030);
        tick();
        tick();
        for (int i = 0; i < 10; i++) begin
            check("t4_no_fetch", inst_rd, 1'b0);
            check("t4_pc_hold", inst_addr, 12'h030);
            tick();
        end
        nu_idle = 1'b1;
        tick();
        check("t4_fetch_after_sync", inst_rd, 1'b1);
        check("t4_pc_adv", inst_addr, 12'h031);
        wait_done("t4_done", 20, 1'b0);

        // pc wraps from 4095 to 0
        mem[12'hFFF] = NOP;
        mem[0]       = HALT;
        d0 = done_cnt;
        do_start(12'hFFF);
        check("t5_start_addr", inst_addr, 12'hFFF);
        tick();
        tick();
        tick();
        check("t5_wrap_rd", inst_rd, 1'b1);
        check("t5_wrap_addr", inst_addr, 12'h000);
        wait_done("t5_done", 20, 1'b0);
        check("t5_done_count", done_cnt - d0, 1);

        // Illegal opcode: err set, no done, back to IDLE
        mem[12'h40] = 32'h7000_0000;
        d0 = done_cnt;
        do_start(12'h040);
        tick();
        tick();
        check("t6_no_done", done, 1'b0);
        tick();
        check("t6_idle", busy, 1'b0);
        check("t6_err", err, 1'b1);
        tick();
        check("t6_err_sticky", err, 1'b1);
        check("t6_done_count", done_cnt - d0, 0);

        // stop and start in the same IDLE cycle: stop wins
        start_addr = 12'h050;
        start = 1'b1;
        stop  = 1'b1;
        tick();
        start = 1'b0;
        stop  = 1'b0;
        check("t7_stop_wins_idle", busy, 1'b0);
        check("t7_err_kept", err, 1'b1);

        // stop while a command is stalled
        mem[12'h50] = 32'h1000_0050;
        mem[12'h51] = HALT;
        issue_ready = 1'b0;
        d0 = done_cnt;
        do_start(12'h050);
        check("t7_err_cleared", err, 1'b0);
        tick();
        tick();
        check("t7_stalled_valid", issue_valid, 1'b1);
        tick();
        tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("t7_stop_idle", busy, 1'b0);
        check("t7_stop_valid", issue_valid, 1'b0);
        check("t7_stop_pc_kept", inst_addr, 12'h050);
        check("t7_stop_no_done", done_cnt - d0, 0);
        issue_ready = 1'b1;
        exp_q.push_back(32'h1000_0050);
        do_start(12'h050);
        wait_done("t7_rerun_done", 20, 1'b0);
        check("t7_sb_empty", exp_q.size(), 0);

        // Self-jump loops until stop
        mem[12'h70] = 32'h3000_0070;
        do_start(12'h070);
        repeat (20) tick();
        check("t_loop_busy", busy, 1'b1);
        check("t_loop_pc", inst_addr, 12'h070);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("t_loop_stopped", busy, 1'b0);

        // rst during MEMWAIT: outputs drop immediately, then a clean rerun
        do_start(12'h050);
        tick();
        rst = 1'b1;
        #1;
        check("t8_rst_busy", busy, 1'b0);
        check("t8_rst_valid", issue_valid, 1'b0);
        check("t8_rst_rd", inst_rd, 1'b0);
        check("t8_rst_pc", inst_addr, 12'h000);
        tick();
        rst = 1'b0;
        tick();
        exp_q.push_back(32'h1000_0050);
        do_start(12'h050);
        wait_done("t8_rerun_done", 20, 1'b0);
        check("t8_sb_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    // Global time limit so the run always terminates.
    initial begin
        #500000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
